// File: rtl/cia_pkg.sv
// Shared constants for the pipelined carry-increment adder.
package cia_pkg;

  // Operation encoding on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default geometry: operand width and bits per carry-increment block.
  localparam int CIA_WIDTH = 32;
  localparam int CIA_BLK   = 8;

endpackage : cia_pkg

// File: rtl/cia_blk.sv
// One BLK-bit ripple-carry block. It produces the block sum and the block
// carry-out for a given carry-in.
module cia_blk #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           carry
);

  logic c;

  // Bit-serial ripple from LSB to MSB; c carries into the next bit.
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < BLK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry = c;
  end

endmodule : cia_blk

// File: rtl/pipe_cia_adder.sv
// Two-stage pipelined carry-increment adder/subtractor.
// Stage 1 computes per-block ripple sums with block carry-in 0 (block 0 uses
// the real carry-in). Stage 2 ripples the block carries upward and increments
// each upper block's sum where a carry arrives.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A producer holds its data stable while valid is high and ready is low;
// ready never depends on the valid it is paired with.
module pipe_cia_adder
  import cia_pkg::*;
#(
  parameter int WIDTH = CIA_WIDTH,
  parameter int BLK   = CIA_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be a multiple of BLK and at least two blocks wide.
  localparam int NBLK = WIDTH / BLK;

  // Operand conditioning: subtraction is a + ~b + 1.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Stage-1 combinational block results.
  logic [WIDTH-1:0] blk_sum;
  logic [NBLK-1:0]  blk_carry;

  // Stage-1 registers.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_sum;
  logic [NBLK-1:0]  s1_bc;
  logic             s1_sa;
  logic             s1_sb;

  // Stage-2 combinational increment results.
  logic [WIDTH-1:0] fin_sum;
  logic [NBLK-1:0]  fin_carry;
  logic             fin_ovf;

  // Handshake enables.
  logic stage2_ready;
  logic in_xfer;
  logic s2_load;

  // Select effective second operand and carry-in from op.
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    cin_eff = (op == OP_SUB) ? 1'b1 : cin;
  end

  // Stage-1 ripple blocks; only block 0 sees a real carry-in.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cia_blk #(.BLK(BLK)) u_blk (
      .a     (a[k*BLK +: BLK]),
      .b     (b_eff[k*BLK +: BLK]),
      .cin   ((k == 0) ? cin_eff : 1'b0),
      .sum   (blk_sum[k*BLK +: BLK]),
      .carry (blk_carry[k])
    );
  end

  // Pipeline flow control: a stage may load when it is empty or draining.
  always_comb begin
    stage2_ready = !out_valid || out_ready;
    in_ready     = !s1_valid || stage2_ready;
    in_xfer      = in_valid && in_ready;
    s2_load      = s1_valid && stage2_ready;
  end

  // Stage-1 register: capture block sums, block carries and operand signs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_bc    <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_xfer) begin
        s1_sum <= blk_sum;
        s1_bc  <= blk_carry;
        s1_sa  <= a[WIDTH-1];
        s1_sb  <= b_eff[WIDTH-1];
      end
    end
  end

  // Carry-increment: ripple block carries upward and bump upper block sums.
  always_comb begin
    fin_sum      = s1_sum;
    fin_carry    = '0;
    fin_carry[0] = s1_bc[0];
    for (int k = 1; k < NBLK; k++) begin
      fin_sum[k*BLK +: BLK] = s1_sum[k*BLK +: BLK] + {{(BLK-1){1'b0}}, fin_carry[k-1]};
      fin_carry[k]          = s1_bc[k] | (fin_carry[k-1] & (&s1_sum[k*BLK +: BLK]));
    end
    fin_ovf = (s1_sa == s1_sb) && (fin_sum[WIDTH-1] != s1_sa);
  end

  // Output register: holds while stalled, loads when stage 2 can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (stage2_ready) begin
        out_valid <= s1_valid;
      end
      if (s2_load) begin
        s    <= fin_sum;
        cout <= fin_carry[NBLK-1];
        ovf  <= fin_ovf;
      end
    end
  end

endmodule : pipe_cia_adder

// File: tb/tb_pipe_cia_adder.sv
// Directed bench for pipe_cia_adder at WIDTH=32, BLK=8.
module tb_pipe_cia_adder;
  import cia_pkg::*;

  localparam int W = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, s;

  pipe_cia_adder #(.WIDTH(W), .BLK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  // Scoreboard: {cout, ovf, s}
  logic [W+1:0] exp_q[$];
  logic [W-1:0] out_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic ci);
    logic [W:0]   t;
    logic [W-1:0] yy;
    logic         v;
    yy = o ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (o ? 1'b1 : ci)};
    v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_log.push_back(s);
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_unexpected observed=%0h expected=none", s);
        end else begin
          chk("sb_result", {30'd0, cout, ovf, s}, {30'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b, cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation, checked at exact 2-cycle latency.
  task automatic run_one(input string tag, input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, input logic [W-1:0] es,
                         input logic ec, input logic ev);
    in_valid = 1'b1; op = o; a = x; b = y; cin = ci; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, ev);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, i, cyc;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = OP_ADD;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    run_one("add_wrap",   OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_one("add_ovf",    OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_one("sub_neg",    OP_SUB, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",    OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_one("add_cin",    OP_ADD, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0);
    run_one("add_chain",  OP_ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_one("add_mid",    OP_ADD, 32'h12FF34FF, 32'h00010001, 1'b0, 32'h13003500, 1'b0, 1'b0);
    run_one("sub_eq",     OP_SUB, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // Back-to-back stream with consumer stalled on cycles 2-4.
    base = n_out; i = 1; cyc = 1;
    while (i <= 4 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid = 1'b1; op = OP_ADD; cin = 1'b0; a = i; b = i;
      #1;
      if (cyc == 3) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_s", s, 2);
      end
      if (cyc == 4) chk("hold_s", s, 2);
      acc = in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 20 && n_out < base + 4; w++) tick();
    chk("stream_count", n_out - base, 4);
    for (int j = 0; j < 4; j++) begin
      if (base + j < out_log.size()) chk("stream_val", out_log[base + j], 2 * (j + 1));
    end

    // Reset with two transactions in flight.
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; cin = 1'b0;
    a = 32'd10; b = 32'd20;
    tick();
    a = 32'd30; b = 32'd40;
    tick();
    in_valid = 1'b0;
    chk("flight_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      tick();
      chk("after_rst_idle", out_valid, 0);
    end
    run_one("post_rst_add", OP_ADD, 32'd3, 32'd4, 1'b1, 32'd8, 1'b0, 1'b0);

    // Mixed traffic with random valid/ready, checked by the scoreboard.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      a         = $urandom;
      b         = $urandom;
      cin       = ($urandom_range(0, 1) == 1);
      op        = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_cia_adder
